// File: rtl/misc_control_watchdog_pkg.sv
// Shared constants and types for the misc control / video count / watchdog block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package misc_control_watchdog_pkg;

    // C9xx control register bit positions
    localparam int E_ROM_BIT      = 0;
    localparam int SCREEN_CTL_BIT = 1;

    // Data value written to CBxx odd that restarts the frame count
    localparam logic [7:0] WDOG_KICK_DEFAULT = 8'h39;

    typedef enum logic {
        WD_RUN   = 1'b0,
        WD_RESET = 1'b1
    } wd_state_e;

endpackage

// File: rtl/misc_control_watchdog_if.sv
// MPU bus-side view of the block: strobe, direction, chip selects, write and read data.
// Latency: n/a (signal bundle).
// Backpressure: none; the MPU bus cycle cannot be stalled.
// master = MPU/decoder side, slave = misc_control_watchdog.
interface misc_control_watchdog_if;
    logic       bus_strobe;
    logic       r_w_n;
    logic [7:0] data_i;
    logic       reg_misc_cs;
    logic       video_count_cs;
    logic       watchdog_cs;
    logic [7:0] data_o;
    logic       data_oe;

    modport master (
        output bus_strobe, r_w_n, data_i, reg_misc_cs, video_count_cs, watchdog_cs,
        input  data_o, data_oe
    );

    modport slave (
        input  bus_strobe, r_w_n, data_i, reg_misc_cs, video_count_cs, watchdog_cs,
        output data_o, data_oe
    );
endinterface

// File: rtl/misc_control_watchdog_watchdog_timer.sv
// Frame-counting watchdog: counts vsyncs since the last kick and emits a fixed-width reset pulse.
// Latency: cpu_reset_req rises 2 clks after the expiring vsync, held RESET_CYCLES clks.
// Backpressure: none; kicks and vsyncs arriving during the reset pulse are dropped.
// Ports: clk, reset_n, kick, vsync_pulse, wdog_enable in; cpu_reset_req out.
module watchdog_timer
    import misc_control_watchdog_pkg::*;
#(
    parameter int WDOG_FRAMES  = 8,
    parameter int RESET_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic kick,
    input  logic vsync_pulse,
    input  logic wdog_enable,
    output logic cpu_reset_req
);

    localparam int         RW         = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LOAD = RW'(RESET_CYCLES - 1);
    localparam logic [7:0] FRAMES_LIM = 8'(WDOG_FRAMES);

    wd_state_e     state, state_nxt;
    logic [7:0]    frame_cnt, frame_nxt;
    logic [RW-1:0] rst_cnt, rst_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= WD_RUN;
            frame_cnt     <= 8'd0;
            rst_cnt       <= '0;
            cpu_reset_req <= 1'b0;
        end else begin
            state         <= state_nxt;
            frame_cnt     <= frame_nxt;
            rst_cnt       <= rst_nxt;
            // Registered from the current state, so the pulse lags the state by one clk
            cpu_reset_req <= (state == WD_RESET);
        end
    end

    always_comb begin
        state_nxt = state;
        frame_nxt = frame_cnt;
        rst_nxt   = rst_cnt;
        case (state)
            WD_RUN: begin
                // Kick has priority over a coincident vsync; counter saturates at 8'hFF
                if (kick) begin
                    frame_nxt = 8'd0;
                end else if (vsync_pulse && wdog_enable && (frame_cnt != 8'hFF)) begin
                    frame_nxt = frame_cnt + 8'd1;
                end
                if (frame_nxt >= FRAMES_LIM) begin
                    state_nxt = WD_RESET;
                    rst_nxt   = RST_LOAD;
                end
            end
            WD_RESET: begin
                if (rst_cnt == '0) begin
                    state_nxt = WD_RUN;
                    frame_nxt = 8'd0;
                end else begin
                    rst_nxt = rst_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = WD_RUN;
                frame_nxt = 8'd0;
            end
        endcase
    end

endmodule

// File: rtl/misc_control_watchdog.sv
// C9xx control register, CB00 tear-free video-count read and CBFF watchdog for the MPU.
// Latency: C9xx write visible 1 clk after strobe; CB00 read data combinational from snapshot.
// Backpressure: none; every strobed bus cycle is accepted.
// Ports: clk, reset_n; bus (slave modport: strobe, r_w_n, data_i, selects, data_o, data_oe);
//        video_count, vsync_pulse, wdog_enable in; e_rom, screen_control, cpu_reset_req out.
module misc_control_watchdog
    import misc_control_watchdog_pkg::*;
#(
    parameter int         WDOG_FRAMES  = 8,
    parameter logic [7:0] WDOG_KICK    = WDOG_KICK_DEFAULT,
    parameter int         RESET_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    misc_control_watchdog_if.slave      bus,
    input  logic [7:0]                  video_count,
    input  logic                        vsync_pulse,
    input  logic                        wdog_enable,
    output logic                        e_rom,
    output logic                        screen_control,
    output logic                        cpu_reset_req
);

    logic       ctl_wr;
    logic       cnt_rd;
    logic       kick;
    logic [7:0] snap;

    assign ctl_wr = bus.bus_strobe & bus.reg_misc_cs & ~bus.r_w_n;
    assign cnt_rd = bus.video_count_cs & bus.r_w_n;
    // Only the exact kick value on a write counts; reads and other values are ignored
    assign kick   = bus.bus_strobe & bus.watchdog_cs & ~bus.r_w_n & (bus.data_i == WDOG_KICK);

    // Control register: only reset_n clears it, the watchdog pulse does not
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_rom          <= 1'b0;
            screen_control <= 1'b0;
        end else if (ctl_wr) begin
            e_rom          <= bus.data_i[E_ROM_BIT];
            screen_control <= bus.data_i[SCREEN_CTL_BIT];
        end
    end

    // Snapshot tracks the live count except while a read is in progress,
    // so the MPU sees one stable value for the whole bus cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap <= 8'd0;
        end else if (!cnt_rd) begin
            snap <= video_count;
        end
    end

    always_comb begin
        bus.data_oe = cnt_rd;
        bus.data_o  = cnt_rd ? snap : 8'd0;
    end

    watchdog_timer #(
        .WDOG_FRAMES  (WDOG_FRAMES),
        .RESET_CYCLES (RESET_CYCLES)
    ) u_watchdog_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .kick          (kick),
        .vsync_pulse   (vsync_pulse),
        .wdog_enable   (wdog_enable),
        .cpu_reset_req (cpu_reset_req)
    );

endmodule
